mem_request_master: RTL and testbench

MEM_REQUEST_MASTER -- requirements
Module: mem_request_master

---
 rtl/mem_request_master.sv | 167 ++++++++++++++++
 tb/tb_mem_request_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_master.sv
// mem_request_master: accepts one user command at a time, issues it to a
// RAM/ROM controller over a strobe/ack handshake with a bidirectional data
// bus, and returns a response carrying read data or a timeout error.
module mem_request_master #(
    parameter int ADDRESS_SIZE = 24,
    parameter int DATA_SIZE    = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmdValid,
    output logic                    cmdReady,
    input  logic [ADDRESS_SIZE-1:0] cmdAddr,
    input  logic [DATA_SIZE-1:0]    cmdData,
    input  logic                    cmdChip,
    input  logic                    cmdLength,
    input  logic                    cmdOp,
    output logic                    rspValid,
    input  logic                    rspReady,
    output logic [DATA_SIZE-1:0]    rspData,
    output logic                    rspError,
    output logic [7:0]              errCount,
    output logic [ADDRESS_SIZE-1:0] ctrlAddr,
    output logic                    ctrlChipSelect,
    output logic                    ctrlLengthSelect,
    output logic                    ctrlOpSelect,
    inout  wire  [DATA_SIZE-1:0]    ctrlData,
    output logic                    ctrlRequest,
    input  logic                    ctrlAck,
    input  logic                    ctrlReady
);

    // Timer only has to count up to TIMEOUT-1 before the abort fires.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    // Low byte mask used to zero-extend 8-bit reads.
    localparam logic [DATA_SIZE-1:0] BYTE_MASK = DATA_SIZE'(8'hFF);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        RESPOND  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0]    data_q, data_d;
    logic                    chip_q, chip_d;
    logic                    len_q, len_d;
    logic                    op_q, op_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic [DATA_SIZE-1:0]    rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    drive_en;

    // Handshake outputs and bus drive enable derived from the current state.
    always_comb begin
        cmdReady    = (state_q == IDLE);
        rspValid    = (state_q == RESPOND);
        ctrlRequest = (state_q == ISSUE) && ctrlReady;
        // Write data is on the bus from the request cycle through the ack
        // cycle; an async reset forces IDLE, so the bus releases at once.
        drive_en    = op_q && (ctrlRequest || (state_q == WAIT_ACK));
    end

    assign ctrlData         = drive_en ? data_q : {DATA_SIZE{1'bz}};
    assign ctrlAddr         = addr_q;
    assign ctrlChipSelect   = chip_q;
    assign ctrlLengthSelect = len_q;
    assign ctrlOpSelect     = op_q;
    assign rspData          = rsp_data_q;
    assign rspError         = rsp_err_q;
    assign errCount         = err_cnt_q;

    // Next-state logic: command latch, issue, ack/timeout race, response hold.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        chip_d     = chip_q;
        len_d      = len_q;
        op_d       = op_q;
        timer_d    = timer_q;
        err_cnt_d  = err_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmdValid) begin
                    addr_d  = cmdAddr;
                    data_d  = cmdData;
                    chip_d  = cmdChip;
                    len_d   = cmdLength;
                    op_d    = cmdOp;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // No timeout here: a busy controller may stall indefinitely.
                if (ctrlReady) begin
                    timer_d = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                timer_d = timer_q + 1'b1;
                // Ack is tested first so it wins a tie with the timeout.
                if (ctrlAck) begin
                    rsp_err_d  = 1'b0;
                    if (op_q) begin
                        rsp_data_d = '0;
                    end else if (len_q) begin
                        rsp_data_d = ctrlData;
                    end else begin
                        rsp_data_d = ctrlData & BYTE_MASK;
                    end
                    state_d = RESPOND;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                // Returning to IDLE here means a command can only be taken
                // on the following cycle.
                if (rspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            chip_q     <= 1'b0;
            len_q      <= 1'b0;
            op_q       <= 1'b0;
            timer_q    <= '0;
            err_cnt_q  <= 8'd0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            chip_q     <= chip_d;
            len_q      <= len_d;
            op_q       <= op_d;
            timer_q    <= timer_d;
            err_cnt_q  <= err_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_request_master.sv
// Bench for mem_request_master: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_request_master;

    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmdValid = 1'b0;
    logic          cmdReady;
    logic [AW-1:0] cmdAddr = '0;
    logic [DW-1:0] cmdData = '0;
    logic          cmdChip = 1'b0;
    logic          cmdLength = 1'b0;
    logic          cmdOp = 1'b0;
    logic          rspValid;
    logic          rspReady = 1'b0;
    logic [DW-1:0] rspData;
    logic          rspError;
    logic [7:0]    errCount;
    logic [AW-1:0] ctrlAddr;
    logic          ctrlChipSelect;
    logic          ctrlLengthSelect;
    logic          ctrlOpSelect;
    wire  [DW-1:0] ctrlData;
    logic          ctrlRequest;
    logic          ctrlAck = 1'b0;
    logic          ctrlReady = 1'b0;

    logic          tb_en = 1'b0;
    logic [DW-1:0] tb_val = '0;

    // Undriven bus reads as zero, so "released" is observable as 0.
    assign ctrlData = tb_en ? tb_val : {DW{1'bz}};
    pulldown (ctrlData);

    int checks = 0;
    int errors = 0;
    int model_err = 0;

    mem_request_master #(
        .ADDRESS_SIZE(AW),
        .DATA_SIZE(DW),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdAddr(cmdAddr),
        .cmdData(cmdData), .cmdChip(cmdChip), .cmdLength(cmdLength), .cmdOp(cmdOp),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
        .rspError(rspError), .errCount(errCount),
        .ctrlAddr(ctrlAddr), .ctrlChipSelect(ctrlChipSelect),
        .ctrlLengthSelect(ctrlLengthSelect), .ctrlOpSelect(ctrlOpSelect),
        .ctrlData(ctrlData), .ctrlRequest(ctrlRequest),
        .ctrlAck(ctrlAck), .ctrlReady(ctrlReady)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction. rdly = cycles ctrlReady stays low in ISSUE;
    // ackc = WAIT_ACK cycle (1-based) carrying ctrlAck, values outside
    // 1..TMO mean no ack at all.
    task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic chip, input logic len, input logic op,
                           input int rdly, input int ackc, input logic [DW-1:0] bus);
        logic          acked;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        int            j;
        int            nhold;
        cmdValid = 1'b1; cmdAddr = a; cmdData = d;
        cmdChip = chip; cmdLength = len; cmdOp = op;
        ctrlReady = (rdly == 0);
        ctrlAck = 1'b0;
        @(negedge clk);
        chk("cmd_ready_idle", cmdReady, 1);
        @(posedge clk); #1;
        cmdValid = 1'b0;
        cmdData = DW'($urandom);
        cmdAddr = AW'($urandom);
        for (int i = 0; i < rdly; i++) begin
            ctrlAck = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("req_gated", ctrlRequest, 0);
            chk("cmd_ready_busy", cmdReady, 0);
            @(posedge clk); #1;
        end
        ctrlReady = 1'b1;
        ctrlAck = 1'b0;
        @(negedge clk);
        chk("req_pulse", ctrlRequest, 1);
        chk("ctrl_addr", ctrlAddr, a);
        chk("ctrl_chip", ctrlChipSelect, chip);
        chk("ctrl_len", ctrlLengthSelect, len);
        chk("ctrl_op", ctrlOpSelect, op);
        chk("bus_at_req", ctrlData, op ? d : '0);
        @(posedge clk); #1;
        ctrlReady = 1'($urandom_range(0, 1));
        acked = 1'b0;
        j = 1;
        while (1) begin
            if (j == ackc) begin
                ctrlAck = 1'b1;
                if (!op) begin
                    tb_en = 1'b1;
                    tb_val = bus;
                end
            end
            @(negedge clk);
            chk("req_once", ctrlRequest, 0);
            chk("rsp_early", rspValid, 0);
            chk("addr_stable", ctrlAddr, a);
            chk("bus_wait", ctrlData, op ? d : ((j == ackc) ? bus : '0));
            @(posedge clk); #1;
            ctrlAck = 1'b0;
            tb_en = 1'b0;
            if (j == ackc) begin
                acked = 1'b1;
                break;
            end
            if (j >= TMO) break;
            j++;
        end
        if (acked) begin
            exp_err = 1'b0;
            exp_data = op ? '0 : (len ? bus : {8'h00, bus[7:0]});
        end else begin
            exp_err = 1'b1;
            exp_data = '0;
            if (model_err < 255) model_err++;
        end
        nhold = $urandom_range(0, 2);
        for (int i = 0; i <= nhold; i++) begin
            if (i == nhold) begin
                rspReady = 1'b1;
                cmdValid = 1'b1;
            end
            ctrlAck = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rsp_valid", rspValid, 1);
            chk("rsp_data", rspData, exp_data);
            chk("rsp_error", rspError, exp_err);
            chk("err_count", errCount, model_err);
            chk("cmd_ready_rsp", cmdReady, 0);
            chk("bus_released", ctrlData, '0);
            @(posedge clk); #1;
        end
        rspReady = 1'b0;
        cmdValid = 1'b0;
        ctrlAck = 1'b0;
        @(negedge clk);
        chk("rsp_done", rspValid, 0);
        chk("no_accept_on_consume", cmdReady, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", rspValid, 0);
        chk("rst_rsp_error", rspError, 0);
        chk("rst_rsp_data", rspData, 0);
        chk("rst_err_count", errCount, 0);
        chk("rst_ctrl_req", ctrlRequest, 0);
        chk("rst_ctrl_addr", ctrlAddr, 0);
        chk("rst_selects", {ctrlChipSelect, ctrlLengthSelect, ctrlOpSelect}, 0);
        chk("rst_bus", ctrlData, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;

        // Word read, byte write, byte read
        run_txn(24'h000100, 16'h0000, 1'b0, 1'b1, 1'b0, 0, 3, 16'hBEEF);
        run_txn(24'h123456, 16'h00A5, 1'b1, 1'b0, 1'b1, 0, 2, 16'h0000);
        run_txn(24'h000200, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 1, 16'h7F3C);

        // Ready gating followed by a timeout
        run_txn(24'h00ABCD, 16'h0000, 1'b1, 1'b1, 1'b0, 10, 0, 16'h0000);

        // Ack in the exact timeout cycle
        run_txn(24'h000300, 16'h0000, 1'b0, 1'b1, 1'b0, 1, TMO, 16'h1234);
        run_txn(24'h000304, 16'h5A5A, 1'b0, 1'b1, 1'b1, 2, TMO, 16'h0000);

        // Reset during WAIT_ACK of a write
        cmdValid = 1'b1; cmdAddr = 24'h0F0F0F; cmdData = 16'hC3C3;
        cmdChip = 1'b0; cmdLength = 1'b1; cmdOp = 1'b1; ctrlReady = 1'b1;
        @(posedge clk); #1;
        cmdValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_bus_driven", ctrlData, 16'hC3C3);
        #2;
        rst = 1'b0;
        #1;
        model_err = 0;
        chk("mid_rst_bus_z", ctrlData, 0);
        chk("mid_rst_rsp_valid", rspValid, 0);
        chk("mid_rst_ctrl_req", ctrlRequest, 0);
        chk("mid_rst_ctrl_addr", ctrlAddr, 0);
        chk("mid_rst_err_count", errCount, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        ctrlReady = 1'b0;
        @(posedge clk); #1;
        run_txn(24'h000400, 16'h0000, 1'b0, 1'b1, 1'b0, 0, 2, 16'h9876);

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            run_txn(AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(1, TMO + 3), DW'($urandom));
        end

        // Saturation of the timeout counter
        for (int n = 0; n < 300; n++) begin
            run_txn(AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    0, 0, '0);
        end
        @(negedge clk);
        chk("err_count_sat", errCount, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
